riscv_inst_encoder: RTL and testbench
=====================================

// Module: riscv_inst_encoder
// PURPOSE
//  Inverse of the immediate decoder: packs opcode, register, funct and a 32-bit immediate into a RV32I instruction word.
//  Range- and alignment-checks the immediate for its format; 2-stage valid/ready pipeline with back-pressure.
//  Sits between the debug/test-program injector and the fetch-side instruction mux. Also counts errored requests.
// PARAMETERS
//  INST_DATA_WIDTH  `CFG_INST_DATA_WIDTH (32)  instruction/immediate width; only 32 is supported
//  ERR_CNT_WIDTH    16                         width of saturating error counter
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst_n      in   1   reset, synchronous, active-low
//  in_valid   in   1   request valid
//  in_ready   out  1   request accepted when in_valid && in_ready
//  in_opcode  in   5   instruction[6:2]; encoder forces [1:0]=2'b11
//  in_rd      in   5   destination register
//  in_rs1     in   5   source register 1
//  in_rs2     in   5   source register 2
//  in_funct3  in   3   funct3
//  in_funct7  in   7   funct7 (R-type only)
//  in_imm     in   32  byte-offset / value immediate, sign-extended form
//  out_valid  out  1   result valid
//  out_ready  in   1   result consumed when out_valid && out_ready
//  out_inst   out  32  encoded instruction
//  out_err    out  2   00 ok, 01 imm out of range, 10 imm misaligned, 11 unsupported opcode
//  err_cnt    out  ERR_CNT_WIDTH  number of results issued with out_err!=0, saturating
// BEHAVIOUR
//  Reset (rst_n==0 at edge): s1/s2 valid=0, out_valid=0, out_inst=0, out_err=0, err_cnt=0; inputs ignored.
//  Format by opcode: 01101 LUI,00101 AUIPC=U; 11011=J; 11001,00000,00100,11100=I; 11000=B; 01000=S;
//   01100=R; any other -> err 11.
//  Field placement: rd[11:7] (U,J,I,R); funct3[14:12], rs1[19:15] (I,S,B,R); rs2[24:20] (S,B,R); funct7[31:25] (R).
//  Imm placement: U [31:12]=imm[31:12]; I [31:20]=imm[11:0]; S [31:25]=imm[11:5],[11:7]=imm[4:0];
//   B [31]=imm[12],[30:25]=imm[10:5],[11:8]=imm[4:1],[7]=imm[11];
//   J [31]=imm[20],[30:21]=imm[10:1],[20]=imm[11],[19:12]=imm[19:12].
//  Checks: U requires imm[11:0]==0; I,S require imm[31:11] all equal; B requires imm[0]==0 and imm[31:12]
//   all equal; J requires imm[0]==0 and imm[31:20] all equal; R ignores imm.
//  Error priority: 11 > 10 > 01. Any error: out_inst=32'h0000_0013 (NOP).
//  Stage 1 registers request + check results; stage 2 registers packed word -> outputs. Latency 2 cycles.
//  Stall: s2 holds when out_valid && !out_ready; s1 advances iff s2 empty or draining;
//   in_ready = !s1_valid || s1_advance (combinational, no input->in_ready path from in_valid).
//  Full throughput 1/cycle when out_ready=1; outputs stable while out_valid && !out_ready.
//  err_cnt increments on each handshake at output with out_err!=0; holds at all-ones.
//  Decoder round-trip: for legal requests, decoding out_inst yields in_imm (I/S/B/J) or imm[31:12]<<12 (U).
// TESTING
//  ADDI op=00100 rd=1 rs1=0 f3=0 imm=FFFFFFFF -> out_inst=FFF00093, err=00, 2 cycles after accept.
//  LUI rd=5 imm=12345000 -> 123452B7 err 00; imm=12345001 -> 00000013 err 01, err_cnt+1.
//  JAL rd=1 imm=00000800 -> 001000EF; BRANCH imm=3 -> err 10; imm=00001000 -> err 01; op=11111 -> err 11.
//  out_ready=0 for 5 cycles, 3 back-to-back requests -> 2 accepted, in_ready=0, order preserved, out_inst stable.
//  rst_n=0 one cycle with both stages full -> next cycle out_valid=0, in_ready=1, err_cnt=0.
//  Random legal requests, all formats, random out_ready -> decoder round-trip imm match, no drops/dups.

Source files
------------

// File: rtl/riscv_inst_encoder.sv
// RV32I instruction encoder: packs opcode/register/funct/immediate fields into an instruction word,
// range/alignment-checks the immediate, and issues through a 2-stage valid/ready pipeline.
module riscv_inst_encoder #(
    parameter int unsigned INST_DATA_WIDTH = 32,
    parameter int unsigned ERR_CNT_WIDTH   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [4:0]                 in_opcode,
    input  logic [4:0]                 in_rd,
    input  logic [4:0]                 in_rs1,
    input  logic [4:0]                 in_rs2,
    input  logic [2:0]                 in_funct3,
    input  logic [6:0]                 in_funct7,
    input  logic [INST_DATA_WIDTH-1:0] in_imm,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INST_DATA_WIDTH-1:0] out_inst,
    output logic [1:0]                 out_err,
    output logic [ERR_CNT_WIDTH-1:0]   err_cnt
);
    typedef enum logic [2:0] {FMT_U, FMT_J, FMT_I, FMT_S, FMT_B, FMT_R, FMT_BAD} fmt_e;

    localparam logic [INST_DATA_WIDTH-1:0] NOP = 32'h0000_0013;

    fmt_e                       w_fmt;
    logic [1:0]                 w_err;
    logic                       w_ext11, w_ext12, w_ext20;
    logic                       w_s2_ready;
    logic [INST_DATA_WIDTH-1:0] w_inst;
    logic [6:0]                 w_opc;

    logic                       r_s1_valid;
    fmt_e                       r_s1_fmt;
    logic [1:0]                 r_s1_err;
    logic [4:0]                 r_s1_op, r_s1_rd, r_s1_rs1, r_s1_rs2;
    logic [2:0]                 r_s1_f3;
    logic [6:0]                 r_s1_f7;
    logic [INST_DATA_WIDTH-1:0] r_s1_imm;

    logic                       r_out_valid;
    logic [INST_DATA_WIDTH-1:0] r_out_inst;
    logic [1:0]                 r_out_err;
    logic [ERR_CNT_WIDTH-1:0]   r_err_cnt;

    always_comb begin
        w_fmt = FMT_BAD;
        case (in_opcode)
            5'b01101, 5'b00101:                     w_fmt = FMT_U;
            5'b11011:                               w_fmt = FMT_J;
            5'b11001, 5'b00000, 5'b00100, 5'b11100: w_fmt = FMT_I;
            5'b11000:                               w_fmt = FMT_B;
            5'b01000:                               w_fmt = FMT_S;
            5'b01100:                               w_fmt = FMT_R;
            default:                                w_fmt = FMT_BAD;
        endcase
    end

    // Immediate fits when every bit above the field's sign bit equals that sign bit
    assign w_ext11 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign w_ext12 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign w_ext20 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

    always_comb begin
        w_err = 2'b00;
        case (w_fmt)
            FMT_U:        if (in_imm[11:0] != '0) w_err = 2'b01;
            FMT_I, FMT_S: if (!w_ext11) w_err = 2'b01;
            FMT_B:        if (in_imm[0]) w_err = 2'b10; else if (!w_ext12) w_err = 2'b01;
            FMT_J:        if (in_imm[0]) w_err = 2'b10; else if (!w_ext20) w_err = 2'b01;
            FMT_R:        w_err = 2'b00;
            default:      w_err = 2'b11;
        endcase
    end

    assign w_s2_ready = !r_out_valid || out_ready;
    assign in_ready   = !r_s1_valid || w_s2_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_fmt   <= FMT_BAD;
            r_s1_err   <= '0;
            r_s1_op    <= '0;
            r_s1_rd    <= '0;
            r_s1_rs1   <= '0;
            r_s1_rs2   <= '0;
            r_s1_f3    <= '0;
            r_s1_f7    <= '0;
            r_s1_imm   <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_fmt <= w_fmt;
                r_s1_err <= w_err;
                r_s1_op  <= in_opcode;
                r_s1_rd  <= in_rd;
                r_s1_rs1 <= in_rs1;
                r_s1_rs2 <= in_rs2;
                r_s1_f3  <= in_funct3;
                r_s1_f7  <= in_funct7;
                r_s1_imm <= in_imm;
            end
        end
    end

    assign w_opc = {r_s1_op, 2'b11};

    always_comb begin
        w_inst = NOP;
        case (r_s1_fmt)
            FMT_U: w_inst = {r_s1_imm[31:12], r_s1_rd, w_opc};
            FMT_J: w_inst = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11], r_s1_imm[19:12], r_s1_rd, w_opc};
            FMT_I: w_inst = {r_s1_imm[11:0], r_s1_rs1, r_s1_f3, r_s1_rd, w_opc};
            FMT_S: w_inst = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_imm[4:0], w_opc};
            FMT_B: w_inst = {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1, r_s1_f3,
                             r_s1_imm[4:1], r_s1_imm[11], w_opc};
            FMT_R: w_inst = {r_s1_f7, r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_rd, w_opc};
            default: w_inst = NOP;
        endcase
        if (r_s1_err != 2'b00) w_inst = NOP;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_inst  <= '0;
            r_out_err   <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (w_s2_ready) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_inst <= w_inst;
                    r_out_err  <= r_s1_err;
                end
            end
            if (r_out_valid && out_ready && (r_out_err != 2'b00) && (r_err_cnt != '1))
                r_err_cnt <= r_err_cnt + {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid = r_out_valid;
    assign out_inst  = r_out_inst;
    assign out_err   = r_out_err;
    assign err_cnt   = r_err_cnt;
endmodule

// File: tb/tb_riscv_inst_encoder.sv
// Directed and randomised checks of riscv_inst_encoder: encodings, error codes, latency,
// back-pressure, reset and decoder round-trip.
module tb_riscv_inst_encoder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode, in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [1:0]  out_err;
    logic [15:0] err_cnt;

    int n_cmp = 0;
    int n_mis = 0;

    typedef struct {
        logic [4:0]  op, rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } req_t;

    req_t q[$];
    req_t cur;
    req_t got;
    logic [4:0] ops[10];

    riscv_inst_encoder #(.INST_DATA_WIDTH(32), .ERR_CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_err(out_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] imm);
        in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    endtask

    // One isolated request with out_ready=1: accept, one empty cycle, result, handshake.
    task automatic req_chk(input string tag, input logic [4:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] imm,
                           input logic [31:0] exp_inst, input logic [1:0] exp_err);
        drive(op, rd, rs1, rs2, f3, f7, imm);
        in_valid = 1'b1;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        step();
        in_valid = 1'b0;
        chk({tag, "_lat1"}, 64'(out_valid), 64'(0));
        step();
        chk({tag, "_valid"}, 64'(out_valid), 64'(1));
        chk({tag, "_inst"}, 64'(out_inst), 64'(exp_inst));
        chk({tag, "_err"}, 64'(out_err), 64'(exp_err));
        step();
    endtask

    // Format class by opcode: 0 U, 1 J, 2 I, 3 S, 4 B, 5 R, 6 other
    function automatic int fclass(input logic [4:0] op);
        case (op)
            5'b01101, 5'b00101:                     return 0;
            5'b11011:                               return 1;
            5'b11001, 5'b00000, 5'b00100, 5'b11100: return 2;
            5'b01000:                               return 3;
            5'b11000:                               return 4;
            5'b01100:                               return 5;
            default:                                return 6;
        endcase
    endfunction

    function automatic logic [31:0] dec_imm(input logic [31:0] i);
        case (fclass(i[6:2]))
            0: return {i[31:12], 12'h000};
            1: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            2: return {{20{i[31]}}, i[31:20]};
            3: return {{20{i[31]}}, i[31:25], i[11:7]};
            4: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] fields(input logic [1:0] lo, input logic [4:0] op,
                                           input logic [4:0] rd, input logic [2:0] f3,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [6:0] f7);
        int c;
        c = fclass(op);
        if (!(c == 0 || c == 1 || c == 2 || c == 5)) rd = '0;
        if (!(c == 2 || c == 3 || c == 4 || c == 5)) begin f3 = '0; rs1 = '0; end
        if (!(c == 3 || c == 4 || c == 5)) rs2 = '0;
        if (c != 5) f7 = '0;
        return {lo, op, f7, rs2, rs1, f3, rd};
    endfunction

    initial begin
        int unsigned sent, rcvd, cyc;
        logic        acc;
        logic [31:0] r;
        int          idx;

        ops = '{5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b00000,
                5'b00100, 5'b11100, 5'b11000, 5'b01000, 5'b01100};
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive(5'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        step(); step();
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_inst", 64'(out_inst), 64'(0));
        chk("rst_out_err", 64'(out_err), 64'(0));
        chk("rst_err_cnt", 64'(err_cnt), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        rst_n = 1'b1;
        step();

        req_chk("addi_m1", 5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 2'b00);
        req_chk("lui_ok", 5'b01101, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 2'b00);
        chk("cnt0", 64'(err_cnt), 64'(0));
        req_chk("lui_rng", 5'b01101, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 32'h0000_0013, 2'b01);
        chk("cnt1", 64'(err_cnt), 64'(1));
        req_chk("jal_800", 5'b11011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h0010_00EF, 2'b00);
        req_chk("jal_min", 5'b11011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF0_0000, 32'h8000_00EF, 2'b00);
        req_chk("sw", 5'b01000, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'h0000_0008, 32'h0020_A423, 2'b00);
        req_chk("sub", 5'b01100, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEAD_BEEF, 32'h4020_81B3, 2'b00);
        req_chk("beq_m4", 5'b11000, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE20_8EE3, 2'b00);
        req_chk("lw_m8", 5'b00000, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 32'hFFFF_FFF8, 32'hFF81_2283, 2'b00);
        req_chk("addi_7ff", 5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_07FF, 32'h7FF0_0093, 2'b00);
        req_chk("addi_800", 5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h0000_0013, 2'b01);
        req_chk("br_mis", 5'b11000, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0000_0003, 32'h0000_0013, 2'b10);
        req_chk("br_rng", 5'b11000, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0000_1000, 32'h0000_0013, 2'b01);
        req_chk("bad_op", 5'b11111, 5'd1, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0000_0003, 32'h0000_0013, 2'b11);
        chk("cnt5", 64'(err_cnt), 64'(5));

        // Back-pressure: three back-to-back requests against a stalled output
        out_ready = 1'b0;
        drive(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        in_valid = 1'b1;
        chk("stall_rdyA", 64'(in_ready), 64'(1));
        step();
        drive(5'b00100, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        chk("stall_rdyB", 64'(in_ready), 64'(1));
        step();
        drive(5'b00100, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        for (int k = 0; k < 4; k++) begin
            chk("stall_rdyC", 64'(in_ready), 64'(0));
            chk("stall_valid", 64'(out_valid), 64'(1));
            chk("stall_instA", 64'(out_inst), 64'(32'h0010_0093));
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("drain_rdy", 64'(in_ready), 64'(1));
        chk("drain_instA", 64'(out_inst), 64'(32'h0010_0093));
        step();
        in_valid = 1'b0;
        chk("drain_vB", 64'(out_valid), 64'(1));
        chk("drain_instB", 64'(out_inst), 64'(32'h0020_0113));
        step();
        chk("drain_vC", 64'(out_valid), 64'(1));
        chk("drain_instC", 64'(out_inst), 64'(32'h0030_0193));
        step();
        chk("drain_empty", 64'(out_valid), 64'(0));

        // Reset with both stages occupied
        out_ready = 1'b0;
        drive(5'b00100, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4);
        in_valid = 1'b1;
        step();
        drive(5'b11111, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4);
        step();
        chk("full_valid", 64'(out_valid), 64'(1));
        chk("full_rdy", 64'(in_ready), 64'(0));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        in_valid = 1'b0;
        chk("rst2_valid", 64'(out_valid), 64'(0));
        chk("rst2_rdy", 64'(in_ready), 64'(1));
        chk("rst2_cnt", 64'(err_cnt), 64'(0));
        chk("rst2_inst", 64'(out_inst), 64'(0));
        step();
        chk("rst2_still_empty", 64'(out_valid), 64'(0));

        // Random legal requests with random back-pressure; decode results and compare
        sent = 0; rcvd = 0; cyc = 0;
        while (rcvd < 40 && cyc < 3000) begin
            cyc++;
            if (!in_valid && sent < 40) begin
                idx = $urandom_range(0, 9);
                r = $urandom;
                cur.op = ops[idx];
                cur.rd = 5'($urandom); cur.rs1 = 5'($urandom); cur.rs2 = 5'($urandom);
                cur.f3 = 3'($urandom); cur.f7 = 7'($urandom);
                case (fclass(cur.op))
                    0: cur.imm = {r[31:12], 12'h000};
                    1: cur.imm = {{11{r[20]}}, r[20:1], 1'b0};
                    4: cur.imm = {{19{r[12]}}, r[12:1], 1'b0};
                    5: cur.imm = r;
                    default: cur.imm = {{20{r[11]}}, r[11:0]};
                endcase
                drive(cur.op, cur.rd, cur.rs1, cur.rs2, cur.f3, cur.f7, cur.imm);
                in_valid = 1'b1;
            end
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_dup", 64'(1), 64'(0));
                end else begin
                    got = q.pop_front();
                    chk("rnd_imm", {30'd0, out_err, dec_imm(out_inst)},
                        {32'd0, (fclass(got.op) == 5) ? 32'h0 : got.imm});
                    chk("rnd_fields",
                        64'(fields(out_inst[1:0], out_inst[6:2], out_inst[11:7], out_inst[14:12],
                                   out_inst[19:15], out_inst[24:20], out_inst[31:25])),
                        64'(fields(2'b11, got.op, got.rd, got.f3, got.rs1, got.rs2, got.f7)));
                end
                rcvd++;
            end
            acc = in_valid && in_ready;
            if (acc) begin
                q.push_back(cur);
                sent++;
            end
            step();
            if (acc) in_valid = 1'b0;
        end
        chk("rnd_rcvd", 64'(rcvd), 64'(40));
        chk("rnd_sent", 64'(sent), 64'(40));
        chk("rnd_queue_empty", 64'(q.size()), 64'(0));
        out_ready = 1'b1;
        step();
        chk("rnd_no_extra", 64'(out_valid), 64'(0));
        chk("rnd_err_cnt", 64'(err_cnt), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
